// File: rtl/aging_table_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : aging_table_arbiter
// Purpose  : Shares the single-port aging table RAM between the connection
//            search path (timestamp refresh writes) and the time-out
//            inspector (scan reads / aged-mark writes). Search has fixed
//            priority with a bounded-starvation guard for the inspector.
//            Inspector reads return through a latency-matched pipeline that
//            flags data overtaken by a search write to the same index.
// Revision : 1.0 - initial release
// ============================================================================
module aging_table_arbiter #(
    parameter int d_agingTb  = 9,
    parameter int w_agingTb  = 9,
    parameter int RD_LATENCY = 2,
    parameter int MAX_STARVE = 4,
    parameter int w_starve   = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 srch_valid,
    input  logic [d_agingTb-1:0] srch_idx,
    input  logic [w_agingTb-1:0] srch_data,
    output logic                 srch_ready,
    input  logic                 insp_rdValid,
    input  logic                 insp_wrValid,
    input  logic [d_agingTb-1:0] insp_idx,
    input  logic [w_agingTb-1:0] insp_data,
    output logic                 insp_ready,
    output logic [w_agingTb-1:0] insp_ctx,
    output logic [d_agingTb-1:0] insp_ctxIdx,
    output logic                 insp_ctxValid,
    output logic                 insp_ctxStale,
    output logic [d_agingTb-1:0] ram_idx,
    output logic [w_agingTb-1:0] ram_data,
    output logic                 ram_rden,
    output logic                 ram_wren,
    input  logic [w_agingTb-1:0] ram_q,
    output logic                 err_rdwr
);

    localparam logic [w_starve-1:0] c_max_starve = w_starve'(MAX_STARVE);

    logic                 w_insp_req;
    logic                 w_force;
    logic                 w_srch_gnt;
    logic                 w_insp_gnt;
    logic [w_starve-1:0]  r_starve_cnt;
    logic                 r_ram_rden;
    logic                 r_ram_wren;
    logic                 r_ram_srch;
    logic [d_agingTb-1:0] r_ram_idx;
    logic [w_agingTb-1:0] r_ram_data;
    logic                 r_err_rdwr;
    logic [RD_LATENCY-1:0] r_pipe_vld;
    logic [RD_LATENCY-1:0] r_pipe_stale;
    logic [d_agingTb-1:0]  r_pipe_idx [RD_LATENCY];
    logic [RD_LATENCY-1:0] w_hit;

    // Grant: search wins unless the inspector has waited MAX_STARVE grants.
    // Nothing is accepted while reset is held.
    assign w_insp_req = insp_rdValid | insp_wrValid;
    assign w_force    = (r_starve_cnt == c_max_starve);
    assign srch_ready = reset & (~w_force | ~w_insp_req);
    assign insp_ready = reset & (~srch_valid | (w_force & w_insp_req));
    assign w_srch_gnt = srch_valid & srch_ready;
    assign w_insp_gnt = w_insp_req & insp_ready;

    // Count consecutive search grants that kept a pending inspector waiting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_starve_cnt <= '0;
        end else if (w_insp_gnt || !w_insp_req) begin
            r_starve_cnt <= '0;
        end else if (w_srch_gnt && (r_starve_cnt != c_max_starve)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    // Register the granted command onto the RAM pins; address/data hold when idle.
    // A combined read+write request is treated as a write only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ram_rden <= 1'b0;
            r_ram_wren <= 1'b0;
            r_ram_srch <= 1'b0;
            r_ram_idx  <= '0;
            r_ram_data <= '0;
        end else begin
            r_ram_rden <= w_insp_gnt & insp_rdValid & ~insp_wrValid;
            r_ram_wren <= w_srch_gnt | (w_insp_gnt & insp_wrValid);
            r_ram_srch <= w_srch_gnt;
            if (w_srch_gnt) begin
                r_ram_idx  <= srch_idx;
                r_ram_data <= srch_data;
            end else if (w_insp_gnt) begin
                r_ram_idx <= insp_idx;
                if (insp_wrValid) begin
                    r_ram_data <= insp_data;
                end
            end
        end
    end

    // Sticky protocol error: inspector asked to read and write at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_rdwr <= 1'b0;
        end else if (insp_rdValid && insp_wrValid) begin
            r_err_rdwr <= 1'b1;
        end
    end

    // A search write now at the RAM pins hits any in-flight read of that index.
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_hit[i] = r_ram_wren & r_ram_srch & r_pipe_vld[i] &
                       (r_pipe_idx[i] == r_ram_idx);
        end
    end

    // First return stage picks up the read issued at the RAM pins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pipe_vld[0]   <= 1'b0;
            r_pipe_stale[0] <= 1'b0;
            r_pipe_idx[0]   <= '0;
        end else begin
            r_pipe_vld[0]   <= r_ram_rden;
            r_pipe_stale[0] <= 1'b0;
            r_pipe_idx[0]   <= r_ram_idx;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < RD_LATENCY; gi++) begin : g_pipe
            // Later stages shift the read forward, accumulating stale hits.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_pipe_vld[gi]   <= 1'b0;
                    r_pipe_stale[gi] <= 1'b0;
                    r_pipe_idx[gi]   <= '0;
                end else begin
                    r_pipe_vld[gi]   <= r_pipe_vld[gi-1];
                    r_pipe_stale[gi] <= r_pipe_stale[gi-1] | w_hit[gi-1];
                    r_pipe_idx[gi]   <= r_pipe_idx[gi-1];
                end
            end
        end
    endgenerate

    // Return path: data and stale flag are qualified by the valid pulse.
    assign insp_ctxValid = r_pipe_vld[RD_LATENCY-1];
    assign insp_ctxIdx   = r_pipe_idx[RD_LATENCY-1];
    assign insp_ctxStale = r_pipe_vld[RD_LATENCY-1] &
                           (r_pipe_stale[RD_LATENCY-1] | w_hit[RD_LATENCY-1]);
    assign insp_ctx      = r_pipe_vld[RD_LATENCY-1] ? ram_q : '0;

    assign ram_idx  = r_ram_idx;
    assign ram_data = r_ram_data;
    assign ram_rden = r_ram_rden;
    assign ram_wren = r_ram_wren;
    assign err_rdwr = r_err_rdwr;

endmodule
`default_nettype wire

// File: tb/tb_aging_table_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_aging_table_arbiter
// Purpose  : Directed self-checking bench for aging_table_arbiter with a
//            two-cycle-latency behavioural model of the aging table RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aging_table_arbiter;

    logic       clk;
    logic       reset;
    logic       srch_valid;
    logic [8:0] srch_idx;
    logic [8:0] srch_data;
    logic       srch_ready;
    logic       insp_rdValid;
    logic       insp_wrValid;
    logic [8:0] insp_idx;
    logic [8:0] insp_data;
    logic       insp_ready;
    logic [8:0] insp_ctx;
    logic [8:0] insp_ctxIdx;
    logic       insp_ctxValid;
    logic       insp_ctxStale;
    logic [8:0] ram_idx;
    logic [8:0] ram_data;
    logic       ram_rden;
    logic       ram_wren;
    logic [8:0] ram_q;
    logic       err_rdwr;

    int errors = 0;
    int checks = 0;

    // RAM model with preload port
    logic [8:0] mem [512];
    logic [8:0] rd_d1;
    logic       pre_we;
    logic [8:0] pre_idx;
    logic [8:0] pre_data;

    aging_table_arbiter #(
        .d_agingTb (9),
        .w_agingTb (9),
        .RD_LATENCY(2),
        .MAX_STARVE(4),
        .w_starve  (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .srch_valid   (srch_valid),
        .srch_idx     (srch_idx),
        .srch_data    (srch_data),
        .srch_ready   (srch_ready),
        .insp_rdValid (insp_rdValid),
        .insp_wrValid (insp_wrValid),
        .insp_idx     (insp_idx),
        .insp_data    (insp_data),
        .insp_ready   (insp_ready),
        .insp_ctx     (insp_ctx),
        .insp_ctxIdx  (insp_ctxIdx),
        .insp_ctxValid(insp_ctxValid),
        .insp_ctxStale(insp_ctxStale),
        .ram_idx      (ram_idx),
        .ram_data     (ram_data),
        .ram_rden     (ram_rden),
        .ram_wren     (ram_wren),
        .ram_q        (ram_q),
        .err_rdwr     (err_rdwr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-before-write RAM, data appears two cycles after the read address
    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_data;
        else if (ram_wren) mem[ram_idx] <= ram_data;
        rd_d1 <= mem[ram_idx];
        ram_q <= rd_d1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [8:0] idx, input logic [8:0] data);
        pre_idx  = idx;
        pre_data = data;
        pre_we   = 1'b1;
        tick();
        pre_we   = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (ram_rden !== 1'b0) begin errors++; $display("FAIL reset_rden: got %b exp 0", ram_rden); end
        checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b exp 0", ram_wren); end
        checks++; if (insp_ctxValid !== 1'b0) begin errors++; $display("FAIL reset_ctxValid: got %b exp 0", insp_ctxValid); end
        checks++; if (err_rdwr !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", err_rdwr); end
        checks++; if (ram_idx !== 9'd0) begin errors++; $display("FAIL reset_ram_idx: got %h exp 000", ram_idx); end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic_read();
        insp_rdValid = 1'b1; insp_idx = 9'd5;
        #1;
        checks++; if (insp_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b exp 1", insp_ready); end
        tick();
        insp_rdValid = 1'b0;
        checks++; if (ram_rden !== 1'b1) begin errors++; $display("FAIL basic_rden: got %b exp 1", ram_rden); end
        checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL basic_wren: got %b exp 0", ram_wren); end
        checks++; if (ram_idx !== 9'd5) begin errors++; $display("FAIL basic_ram_idx: got %h exp 005", ram_idx); end
        tick();
        checks++; if (insp_ctxValid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b exp 0", insp_ctxValid); end
        tick();
        checks++; if (insp_ctxValid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b exp 1", insp_ctxValid); end
        checks++; if (insp_ctx !== 9'h012) begin errors++; $display("FAIL basic_ctx: got %h exp 012", insp_ctx); end
        checks++; if (insp_ctxIdx !== 9'd5) begin errors++; $display("FAIL basic_ctxIdx: got %h exp 005", insp_ctxIdx); end
        checks++; if (insp_ctxStale !== 1'b0) begin errors++; $display("FAIL basic_stale: got %b exp 0", insp_ctxStale); end
        tick();
        checks++; if (insp_ctxValid !== 1'b0) begin errors++; $display("FAIL basic_pulse_end: got %b exp 0", insp_ctxValid); end
    endtask

    task automatic test_starve();
        int run;
        int max_run;
        logic exp_insp;
        run = 0; max_run = 0;
        srch_valid = 1'b1; srch_idx = 9'h1F0; srch_data = 9'h033;
        insp_rdValid = 1'b1; insp_idx = 9'h020;
        for (int k = 0; k < 15; k++) begin
            #1;
            exp_insp = ((k % 5) == 4);
            checks++; if (insp_ready !== exp_insp) begin errors++; $display("FAIL starve_insp_ready[%0d]: got %b exp %b", k, insp_ready, exp_insp); end
            checks++; if (srch_ready !== ~exp_insp) begin errors++; $display("FAIL starve_srch_ready[%0d]: got %b exp %b", k, srch_ready, ~exp_insp); end
            if (insp_ready === 1'b1) run = 0; else run++;
            if (run > max_run) max_run = run;
            tick();
        end
        checks++; if (max_run > 4) begin errors++; $display("FAIL starve_run: got %0d exp <=4", max_run); end
        srch_valid = 1'b0; insp_rdValid = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_stale(input logic [8:0] wr_idx, input logic exp_stale);
        insp_rdValid = 1'b1; insp_idx = 9'd7;
        tick();
        insp_rdValid = 1'b0;
        srch_valid = 1'b1; srch_idx = wr_idx; srch_data = 9'h055;
        #1;
        checks++; if (srch_ready !== 1'b1) begin errors++; $display("FAIL stale_srch_ready: got %b exp 1", srch_ready); end
        tick();
        srch_valid = 1'b0;
        checks++; if (ram_wren !== 1'b1 || ram_idx !== wr_idx || ram_data !== 9'h055) begin
            errors++; $display("FAIL stale_ram_cmd: got wren=%b idx=%h data=%h exp 1/%h/055", ram_wren, ram_idx, ram_data, wr_idx); end
        tick();
        checks++; if (insp_ctxValid !== 1'b1) begin errors++; $display("FAIL stale_valid: got %b exp 1", insp_ctxValid); end
        checks++; if (insp_ctxStale !== exp_stale) begin errors++; $display("FAIL stale_flag(wr %0d): got %b exp %b", wr_idx, insp_ctxStale, exp_stale); end
        checks++; if (insp_ctxIdx !== 9'd7 || insp_ctx !== 9'h0AB) begin
            errors++; $display("FAIL stale_data: got idx=%h ctx=%h exp 007/0ab", insp_ctxIdx, insp_ctx); end
        tick();
        checks++; if (insp_ctxStale !== 1'b0) begin errors++; $display("FAIL stale_idle: got %b exp 0", insp_ctxStale); end
        load(9'd7, 9'h0AB);
    endtask

    task automatic test_rdwr();
        insp_rdValid = 1'b1; insp_wrValid = 1'b1; insp_idx = 9'd3; insp_data = 9'h100;
        #1;
        checks++; if (insp_ready !== 1'b1) begin errors++; $display("FAIL rdwr_ready: got %b exp 1", insp_ready); end
        tick();
        insp_rdValid = 1'b0; insp_wrValid = 1'b0;
        checks++; if (ram_wren !== 1'b1 || ram_rden !== 1'b0) begin
            errors++; $display("FAIL rdwr_cmd: got wren=%b rden=%b exp 1/0", ram_wren, ram_rden); end
        checks++; if (ram_data !== 9'h100 || ram_idx !== 9'd3) begin
            errors++; $display("FAIL rdwr_addr: got idx=%h data=%h exp 003/100", ram_idx, ram_data); end
        checks++; if (err_rdwr !== 1'b1) begin errors++; $display("FAIL rdwr_err: got %b exp 1", err_rdwr); end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (insp_ctxValid !== 1'b0) begin errors++; $display("FAIL rdwr_no_ctx[%0d]: got %b exp 0", k, insp_ctxValid); end
        end
        checks++; if (err_rdwr !== 1'b1) begin errors++; $display("FAIL rdwr_err_sticky: got %b exp 1", err_rdwr); end
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp_ctx;
        for (int k = 0; k < 3; k++) begin
            insp_rdValid = 1'b1; insp_idx = 9'(k);
            #1;
            checks++; if (insp_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b exp 1", k, insp_ready); end
            tick();
        end
        insp_rdValid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_ctx = 9'h0A0 + 9'(k);
            checks++; if (insp_ctxValid !== 1'b1 || insp_ctxIdx !== 9'(k) || insp_ctx !== exp_ctx) begin
                errors++; $display("FAIL b2b_ret[%0d]: got v=%b idx=%h ctx=%h exp 1/%h/%h", k, insp_ctxValid, insp_ctxIdx, insp_ctx, 9'(k), exp_ctx); end
            tick();
        end
        checks++; if (insp_ctxValid !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b exp 0", insp_ctxValid); end
        checks++; if (err_rdwr !== 1'b1) begin errors++; $display("FAIL b2b_err_sticky: got %b exp 1", err_rdwr); end
    endtask

    task automatic test_reset_midflight();
        insp_rdValid = 1'b1; insp_idx = 9'd5;
        tick();
        insp_rdValid = 1'b0;
        checks++; if (ram_rden !== 1'b1) begin errors++; $display("FAIL mid_rden_pre: got %b exp 1", ram_rden); end
        reset = 1'b0;
        #1;
        checks++; if (ram_rden !== 1'b0 || ram_wren !== 1'b0 || ram_idx !== 9'd0 || ram_data !== 9'd0) begin
            errors++; $display("FAIL mid_ram_clear: got rden=%b wren=%b idx=%h data=%h exp 0", ram_rden, ram_wren, ram_idx, ram_data); end
        checks++; if (insp_ctxValid !== 1'b0 || insp_ctxStale !== 1'b0 || insp_ctxIdx !== 9'd0 || insp_ctx !== 9'd0) begin
            errors++; $display("FAIL mid_ctx_clear: got v=%b s=%b idx=%h ctx=%h exp 0", insp_ctxValid, insp_ctxStale, insp_ctxIdx, insp_ctx); end
        checks++; if (err_rdwr !== 1'b0) begin errors++; $display("FAIL mid_err_clear: got %b exp 0", err_rdwr); end
        tick(); tick();
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (insp_ctxValid !== 1'b0) begin errors++; $display("FAIL mid_no_ctx[%0d]: got %b exp 0", k, insp_ctxValid); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        srch_valid = 1'b0; srch_idx = '0; srch_data = '0;
        insp_rdValid = 1'b0; insp_wrValid = 1'b0; insp_idx = '0; insp_data = '0;
        pre_we = 1'b0; pre_idx = '0; pre_data = '0;
        tick();
        load(9'd5, 9'h012);
        load(9'd7, 9'h0AB);
        load(9'd0, 9'h0A0);
        load(9'd1, 9'h0A1);
        load(9'd2, 9'h0A2);
        test_reset();
        test_basic_read();
        test_starve();
        test_stale(9'd7, 1'b1);
        test_stale(9'd8, 1'b0);
        test_rdwr();
        test_back_to_back();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
